tone_sequencer: RTL and testbench

Upstream sample source for the audio codec path. It steps through a note ROM of half-period delay words, one note per beat, and synthesises a bipolar square wave for each note. It presents a held 32-bit signed sample to the audio controller's write port under the controller's audio_out_allowed handshake. It supports start, stop, loop and end-of-tune signalling so game logic can trigger lobby and game-over tunes.

---
 rtl/tone_sequencer.sv | 128 ++++++++++++
 tb/tb_tone_sequencer.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/tone_sequencer.sv
// rtl/tone_sequencer.sv - note-ROM driven square-wave sample source for the audio codec
module tone_sequencer #(
    parameter int ADDR_W      = 10,
    parameter int DELAY_W     = 19,
    parameter int BEAT_CYCLES = 2500000,
    parameter int LAST_ADDR   = 999,
    parameter int AMPLITUDE   = 100000000
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic                start,
    input  logic                stop,
    input  logic                loop_en,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [DELAY_W-1:0]  rom_q,
    input  logic                audio_out_allowed,
    output logic                write_audio_out,
    output logic signed [31:0]  sample_out,
    output logic                busy,
    output logic                done
);
    localparam int BEAT_W = (BEAT_CYCLES > 2) ? $clog2(BEAT_CYCLES) : 1;
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEAT_CYCLES - 1);
    localparam logic [ADDR_W-1:0] LAST_A    = ADDR_W'(LAST_ADDR);
    localparam logic signed [31:0] AMP_POS  = 32'(AMPLITUDE);
    localparam logic signed [31:0] AMP_NEG  = -AMP_POS;

    typedef enum logic [1:0] {IDLE, FETCH, LOAD, PLAY} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DELAY_W-1:0]  delay_q, delay_d;
    logic [DELAY_W-1:0]  half_q, half_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic                phase_q, phase_d;
    logic signed [31:0]  sample_q, sample_d;
    logic                done_q, done_d;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        delay_d  = delay_q;
        half_d   = half_q;
        beat_d   = beat_q;
        phase_d  = phase_q;
        sample_d = sample_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!stop && start) begin
                    state_d = FETCH;
                    addr_d  = '0;
                end
            end
            FETCH: state_d = LOAD;
            LOAD: begin
                delay_d  = rom_q;
                half_d   = '0;
                beat_d   = '0;
                phase_d  = 1'b1;
                sample_d = (rom_q == '0) ? 32'sd0 : AMP_POS;
                state_d  = PLAY;
            end
            PLAY: begin
                beat_d = beat_q + BEAT_W'(1);
                // A zero delay word is a rest: counter parked, output stays silent.
                if (delay_q != '0) begin
                    if (half_q == delay_q) begin
                        half_d   = '0;
                        phase_d  = ~phase_q;
                        sample_d = phase_q ? AMP_NEG : AMP_POS;
                    end else begin
                        half_d = half_q + DELAY_W'(1);
                    end
                end
                if (beat_q == BEAT_LAST) begin
                    sample_d = 32'sd0;
                    if (addr_q < LAST_A) begin
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = FETCH;
                    end else if (loop_en) begin
                        addr_d  = '0;
                        state_d = FETCH;
                    end else begin
                        addr_d  = '0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (stop && state_q != IDLE) begin
            state_d  = IDLE;
            sample_d = 32'sd0;
            addr_d   = '0;
            done_d   = 1'b0;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            delay_q  <= '0;
            half_q   <= '0;
            beat_q   <= '0;
            phase_q  <= 1'b0;
            sample_q <= 32'sd0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            delay_q  <= delay_d;
            half_q   <= half_d;
            beat_q   <= beat_d;
            phase_q  <= phase_d;
            sample_q <= sample_d;
            done_q   <= done_d;
        end
    end

    assign write_audio_out = audio_out_allowed;
    assign rom_addr        = addr_q;
    assign sample_out      = sample_q;
    assign busy            = (state_q != IDLE);
    assign done            = done_q;
endmodule

// File: tb/tb_tone_sequencer.sv
// tb/tb_tone_sequencer.sv - randomized bench for tone_sequencer against a per-cycle note model
module tb_tone_sequencer;
    localparam int B    = 8;
    localparam int LAST = 3;
    localparam int A    = 100000000;
    localparam int NOTE = B + 2;

    logic               CLOCK_50 = 1'b0;
    logic               reset;
    logic               start, stop, loop_en;
    logic [9:0]         rom_addr;
    logic [18:0]        rom_q;
    logic               audio_out_allowed;
    logic               write_audio_out;
    logic signed [31:0] sample_out;
    logic               busy, done;

    logic [18:0] rom [0:1023];

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int   s;
        bit   busy;
        bit   done;
        bit   chk_addr;
        int   addr;
    } exp_t;
    exp_t q[$];

    tone_sequencer #(
        .ADDR_W(10), .DELAY_W(19), .BEAT_CYCLES(B), .LAST_ADDR(LAST), .AMPLITUDE(A)
    ) dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .start(start), .stop(stop), .loop_en(loop_en),
        .rom_addr(rom_addr), .rom_q(rom_q), .audio_out_allowed(audio_out_allowed),
        .write_audio_out(write_audio_out), .sample_out(sample_out), .busy(busy), .done(done)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) rom_q <= rom[rom_addr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h) at %0t",
                     tag, $signed(got), got, $signed(exp), exp, $time);
        end
    endtask

    // Square wave: PLAY cycle k of a note with half-period d+1 is in half-cycle k/(d+1).
    function automatic int tone(input int d, input int k);
        if (d == 0) return 0;
        return (((k / (d + 1)) % 2) == 0) ? A : -A;
    endfunction

    task automatic build(input int passes, input bit loop, input int stop_idx);
        exp_t e;
        q.delete();
        for (int p = 0; p < passes; p++)
            for (int a = 0; a <= LAST; a++)
                for (int c = 0; c < NOTE; c++) begin
                    e.s        = (c < 2) ? 0 : tone(int'(rom[a]), c - 2);
                    e.busy     = 1'b1;
                    e.done     = 1'b0;
                    e.chk_addr = 1'b1;
                    e.addr     = a;
                    q.push_back(e);
                end
        if (!loop) begin
            e.s = 0; e.busy = 1'b0; e.done = 1'b1; e.chk_addr = 1'b0; e.addr = 0;
            q.push_back(e);
        end
        if (stop_idx >= 0) begin
            while (q.size() > stop_idx + 1) void'(q.pop_back());
            e.s = 0; e.busy = 1'b0; e.done = 1'b0; e.chk_addr = 1'b1; e.addr = 0;
            q.push_back(e);
        end
    endtask

    task automatic run_tune(input int passes, input bit loop, input int stop_idx, input bit hold_start);
        build(passes, loop, stop_idx);
        loop_en = loop;
        start   = 1'b1;
        for (int i = 0; i < q.size(); i++) begin
            @(posedge CLOCK_50); #1;
            if (!hold_start) start = 1'b0;
            stop = (i == stop_idx);
            audio_out_allowed = 1'($urandom_range(0, 1));
            @(negedge CLOCK_50);
            chk("sample", sample_out, q[i].s);
            chk("busy", 32'(busy), 32'(q[i].busy));
            chk("done", 32'(done), 32'(q[i].done));
            chk("write", 32'(write_audio_out), 32'(audio_out_allowed));
            if (q[i].chk_addr) chk("addr", 32'(rom_addr), q[i].addr);
        end
        if (hold_start) begin
            @(posedge CLOCK_50); #1;
            start = 1'b0;
            stop  = 1'b1;
            @(negedge CLOCK_50);
            chk("restart_busy", 32'(busy), 32'd1);
            chk("restart_addr", 32'(rom_addr), 32'd0);
            @(posedge CLOCK_50); #1;
        end
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic set_rom(input int w0, input int w1, input int w2, input int w3);
        rom[0] = 19'(w0); rom[1] = 19'(w1); rom[2] = 19'(w2); rom[3] = 19'(w3);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = '0;
        reset = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0; audio_out_allowed = 1'b0;
        repeat (2) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        chk("rst_sample", sample_out, 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_addr", 32'(rom_addr), 0);
        chk("rst_done", 32'(done), 0);
        @(posedge CLOCK_50); #1 reset = 1'b0;

        // Asynchronous reset in the middle of the first note's PLAY phase
        set_rom(2, 0, 1, 3);
        start = 1'b1;
        @(posedge CLOCK_50); #1 start = 1'b0;
        repeat (5) @(posedge CLOCK_50);
        #2 audio_out_allowed = 1'b1;
        chk("pre_rst_busy", 32'(busy), 1);
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_sample", sample_out, 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_addr", 32'(rom_addr), 0);
        chk("mid_rst_write1", 32'(write_audio_out), 1);
        audio_out_allowed = 1'b0;
        #1 chk("mid_rst_write0", 32'(write_audio_out), 0);
        @(posedge CLOCK_50); #1 reset = 1'b0;

        run_tune(1, 1'b0, -1, 1'b0);
        run_tune(3, 1'b1, 2 * 4 * NOTE + 5, 1'b0);
        run_tune(1, 1'b0, 2 * NOTE + 1 + 5, 1'b0);
        run_tune(1, 1'b0, 15, 1'b0);
        run_tune(1, 1'b0, -1, 1'b1);

        set_rom(19'h7FFFF, 0, 1, 3);
        run_tune(1, 1'b0, NOTE + 2, 1'b0);

        for (int r = 0; r < 4; r++) begin
            bit lp;
            int st;
            set_rom($urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5));
            lp = 1'($urandom_range(0, 1));
            if (lp) st = $urandom_range(0, 2 * 4 * NOTE - 1);
            else    st = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 4 * NOTE - 1) : -1;
            run_tune(lp ? 2 : 1, lp, st, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
